// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN weight path (weight store, loader, engine).
package snn_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HI     = 2'd1,
        LO     = 2'd2,
        COMMIT = 2'd3
    } ld_state_e;

    typedef logic signed [3:0] weight_t;
    typedef logic        [7:0] entry_t;

    // Saturation limits for a signed 4-bit weight, shared with the engine.
    localparam weight_t W_MAX = 4'sb0111;
    localparam weight_t W_MIN = 4'sb1000;

    function automatic logic even_parity(input entry_t data);
        return ^data;
    endfunction

endpackage

// File: rtl/snn_weight_store_if.sv
// Engine weight bus plus host nibble-load handshake for snn_weight_store.
interface snn_weight_store_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_rdata;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_we;
    logic              host_start;
    logic              host_valid;
    logic [3:0]        host_nibble;
    logic              host_ready;

    modport master (
        output eng_addr, eng_wdata, eng_we, host_start, host_valid, host_nibble,
        input  eng_rdata, host_ready
    );

    modport slave (
        input  eng_addr, eng_wdata, eng_we, host_start, host_valid, host_nibble,
        output eng_rdata, host_ready
    );
endinterface

// File: rtl/snn_nibble_loader.sv
// Host load FSM: assembles high/low nibble pairs into entries and strobes them out in order.
module snn_nibble_loader
    import snn_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_start,
    input  logic              host_valid,
    input  logic [3:0]        host_nibble,
    output logic              host_ready,
    output logic              busy,
    output logic              loaded,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output entry_t            commit_data
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    weight_t           hi_q, hi_d;
    weight_t           lo_q, lo_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              loaded_q, loaded_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        loaded_d = loaded_q;
        unique case (state_q)
            IDLE: begin
                if (host_start) begin
                    state_d = HI;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            HI: begin
                if (host_valid) begin
                    hi_d    = weight_t'(host_nibble);
                    state_d = LO;
                end
            end
            LO: begin
                if (host_valid) begin
                    lo_d    = weight_t'(host_nibble);
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    loaded_d = 1'b1;
                    ptr_d    = '0;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = HI;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready is registered, so it is derived from the state being entered.
        ready_d = (state_d == HI) || (state_d == LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
        end
    end

    assign host_ready  = ready_q;
    assign busy        = busy_q;
    assign loaded      = loaded_q;
    assign commit      = (state_q == COMMIT);
    assign commit_addr = ptr_q;
    assign commit_data = {hi_q, lo_q};

endmodule

// File: rtl/snn_weight_store.sv
// Weight memory serving engine fetches/write-backs, preloaded by a nibble-serial host port.
// Optional macro WSTORE_PARITY_EN adds a per-entry even-parity bit and a parity_err output.
module snn_weight_store
    import snn_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    snn_weight_store_if.slave  bus,
    output logic               busy,
    output logic               loaded,
    output logic               wr_drop
`ifdef WSTORE_PARITY_EN
    ,
    output logic               parity_err
`endif
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  we_vec;
    logic [DATA_W-1:0] wr_data;
    logic              in_range;
    logic              eng_wr_ok;
    logic              wr_drop_q, wr_drop_d;

    logic              ld_busy;
    logic              ld_commit;
    logic [ADDR_W-1:0] ld_addr;
    entry_t            ld_data;

    snn_nibble_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_start  (bus.host_start),
        .host_valid  (bus.host_valid),
        .host_nibble (bus.host_nibble),
        .host_ready  (bus.host_ready),
        .busy        (ld_busy),
        .loaded      (loaded),
        .commit      (ld_commit),
        .commit_addr (ld_addr),
        .commit_data (ld_data)
    );

    assign in_range  = {1'b0, bus.eng_addr} < (ADDR_W + 1)'(DEPTH);
    // Engine writes are locked out for the whole load, so the two write sources never collide.
    assign eng_wr_ok = bus.eng_we && !ld_busy && in_range;
    assign wr_data   = ld_commit ? DATA_W'(ld_data) : bus.eng_wdata;
    assign wr_drop_d = bus.eng_we && (ld_busy || !in_range);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we_vec[gi] = (ld_commit && (ld_addr == ADDR_W'(gi)))
                         || (eng_wr_ok && (bus.eng_addr == ADDR_W'(gi)));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = we_vec[i] ? wr_data : mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_drop_q <= wr_drop_d;
        end
    end

    assign bus.eng_rdata = in_range ? mem_q[bus.eng_addr] : '0;
    assign busy          = ld_busy;
    assign wr_drop       = wr_drop_q;

`ifdef WSTORE_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            par_d[i] = we_vec[i] ? even_parity(entry_t'(wr_data)) : par_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_err = in_range
                     && (even_parity(entry_t'(mem_q[bus.eng_addr])) != par_q[bus.eng_addr]);
`endif

endmodule

// File: tb/tb_snn_weight_store.sv
// Directed bench for snn_weight_store: reset, full host load, engine write/drop, mid-load reset.
module tb_snn_weight_store;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, loaded, wr_drop;
`ifdef WSTORE_PARITY_EN
    logic parity_err;
    logic [15:0] par_snap;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    snn_weight_store_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    snn_weight_store #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .loaded  (loaded),
        .wr_drop (wr_drop)
`ifdef WSTORE_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_entry(input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'((2 * k) % 16);
        lo = 4'((2 * k + 1) % 16);
        return {hi, lo};
    endfunction

    task automatic read_chk(input string tag, input int a, input logic [7:0] exp);
        bus.eng_addr = 4'(a);
        #1;
        chk($sformatf("%s[%0d]", tag, a), 32'(bus.eng_rdata), 32'(exp));
    endtask

    // Full load with host_valid held high; optional engine write during load and optional abort.
    task automatic do_load(input int drop_k, input int abort_nib);
        int nib;
        nib = 0;
        @(negedge clk);
        bus.host_start  = 1'b1;
        bus.host_valid  = 1'b1;
        bus.host_nibble = 4'h0;
        @(posedge clk);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            bus.host_start = 1'b0;
            if (abort_nib >= 0 && nib == abort_nib) begin
                bus.host_valid = 1'b0;
                return;
            end
            if (k == 48) chk("busy_at_47", 32'(busy), 32'd1);
            if (k == drop_k) begin
                bus.eng_we    = 1'b1;
                bus.eng_addr  = 4'd5;
                bus.eng_wdata = 8'h3C;
            end
            if (k == drop_k + 1) begin
                chk("wr_drop_pulse", 32'(wr_drop), 32'd1);
                bus.eng_we = 1'b0;
            end
            if (k == drop_k + 2) chk("wr_drop_clear", 32'(wr_drop), 32'd0);
            if (bus.host_ready) begin
                bus.host_nibble = 4'(nib);
                nib++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        chk("busy_at_48", 32'(busy), 32'd0);
        chk("loaded_at_48", 32'(loaded), 32'd1);
        chk("ready_after_load", 32'(bus.host_ready), 32'd0);
        chk("nibbles_taken", 32'(nib), 32'd32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.eng_addr    = '0;
        bus.eng_wdata   = '0;
        bus.eng_we      = 1'b0;
        bus.host_start  = 1'b0;
        bus.host_valid  = 1'b0;
        bus.host_nibble = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.host_ready), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        for (int a = 0; a < 16; a++) read_chk("rst_mem", a, 8'h00);

        // First full load
        do_load(-10, -1);
        for (int a = 0; a < 16; a++) read_chk("load_mem", a, exp_entry(a));

        // Engine write: old value visible in the same cycle, new value after the edge
        @(negedge clk);
        bus.eng_we    = 1'b1;
        bus.eng_addr  = 4'd3;
        bus.eng_wdata = 8'hA5;
        #1;
        chk("wr_same_cycle", 32'(bus.eng_rdata), 32'h67);
        @(negedge clk);
        bus.eng_we = 1'b0;
        chk("wr_next_cycle", 32'(bus.eng_rdata), 32'hA5);
        chk("wr_no_drop", 32'(wr_drop), 32'd0);

        // Engine write during a reload is dropped
        do_load(10, -1);
        read_chk("drop_mem", 5, 8'hAB);
        read_chk("reload_mem", 3, 8'h67);

        // Reset after 10 nibbles aborts the load and clears everything
        do_load(-10, 10);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(bus.host_ready), 32'd0);
        chk("abort_loaded", 32'(loaded), 32'd0);
        chk("abort_state", 32'(dut.u_loader.state_q), 32'(IDLE));
        for (int a = 0; a < 16; a++) read_chk("abort_mem", a, 8'h00);

        do_load(-10, -1);
        read_chk("reload2_mem", 0, 8'h01);
        read_chk("reload2_mem", 7, 8'hEF);
        read_chk("reload2_mem", 15, 8'hEF);

`ifdef WSTORE_PARITY_EN
        @(negedge clk);
        bus.eng_we    = 1'b1;
        bus.eng_addr  = 4'd2;
        bus.eng_wdata = 8'h07;
        @(negedge clk);
        bus.eng_we = 1'b0;
        #1;
        chk("par_ok", 32'(parity_err), 32'd0);
        par_snap = dut.par_q;
        force dut.par_q = par_snap ^ 16'h0004;
        #1;
        chk("par_err_addr2", 32'(parity_err), 32'd1);
        bus.eng_addr = 4'd3;
        #1;
        chk("par_err_addr3", 32'(parity_err), 32'd0);
        release dut.par_q;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
